sdram_wr_burst: RTL and testbench



---
 rtl/sdram_wr_burst.sv | 228 ++++++++++++++++++++++
 tb/tb_sdram_wr_burst.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_wr_burst.sv
// rtl/sdram_wr_burst.sv - bank-aware multi-burst SDRAM write engine
//
// Moves wr_len bursts of BURST beats from a first-word-fall-through upstream
// into ACT / WRITE / PRE command sequences. Crosses into the next row (and the
// next bank on row wrap) and yields the bus at burst boundaries when the grant
// drops.
//
// Optional feature macro: SDRAM_WR_AUTOPRE_EN
//   defined   : final WRITE of a session carries A10=1; PRE state issues NOP
//   undefined : A10=0 on every WRITE; PRE state issues an explicit PRE
//
// Ports:
//   sclk, srst_n  clock, asynchronous active-low reset
//   wr_trig       job start pulse (sampled in IDLE only)
//   wr_len        number of bursts in the job (0 ignores the trigger)
//   wr_addr       {bank,row,col} start address
//   wr_data       beat data, consumed when wr_data_en is high
//   wr_en         arbiter grant
//   flag_wr_ask   bus request
//   flag_wr_end   one-cycle pulse when the bus is released
//   wr_busy       job in progress
//   wr_data_en    beat pull strobe (combinational from state)
//   sdram_cmd     {cs_n,ras_n,cas_n,we_n}, registered
//   sdram_addr    row / column address, registered
//   sdram_bank    bank address, registered
//   sdram_data    write data, registered, aligned with its beat
module sdram_wr_burst #(
  parameter int DATA_W = 16,
  parameter int ROW_W  = 12,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2,
  parameter int BURST  = 4,
  parameter int LEN_W  = 8,
  parameter int TRCD   = 2,
  parameter int TWR    = 2,
  parameter int TRP    = 2
) (
  input  logic                            sclk,
  input  logic                            srst_n,
  input  logic                            wr_trig,
  input  logic [LEN_W-1:0]                wr_len,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic                            wr_en,
  output logic                            flag_wr_ask,
  output logic                            flag_wr_end,
  output logic                            wr_busy,
  output logic                            wr_data_en,
  output logic [3:0]                      sdram_cmd,
  output logic [ROW_W-1:0]                sdram_addr,
  output logic [BANK_W-1:0]               sdram_bank,
  output logic [DATA_W-1:0]               sdram_data
);

  localparam int AW    = BANK_W + ROW_W + COL_W;
  localparam int BW    = $clog2(BURST);
  localparam int CNT_W = 8;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  typedef enum logic [2:0] {
    S_IDLE, S_ASK, S_ACT, S_RCD, S_WR, S_WRREC, S_PRE
  } state_t;

  state_t              state;
  logic [BANK_W-1:0]   bank;
  logic [BANK_W-1:0]   act_bank;   // bank of the open row, kept for PRE after a bank wrap
  logic [ROW_W-1:0]    row;
  logic [COL_W-1:0]    col;
  logic [LEN_W-1:0]    remaining;
  logic [CNT_W-1:0]    cnt;
  logic [BW-1:0]       beat;

  logic [COL_W:0]      col_sum;
  logic [ROW_W:0]      row_sum;
  logic [LEN_W-1:0]    rem_dec;
  logic                row_end;
  logic                last_beat;
  logic                burst_stop;
  logic                end_burst;
  logic [ROW_W-1:0]    write_addr;

  assign col_sum    = {1'b0, col} + (COL_W+1)'(BURST);
  assign row_sum    = {1'b0, row} + 1'b1;
  assign rem_dec    = remaining - 1'b1;
  assign row_end    = col_sum[COL_W];
  assign last_beat  = (beat == BW'(BURST - 1));
  assign burst_stop = (rem_dec == '0) || row_end || !wr_en;

  assign flag_wr_ask = (state == S_ASK);
  assign wr_busy     = (state != S_IDLE);
  assign wr_data_en  = (state == S_WR);

`ifdef SDRAM_WR_AUTOPRE_EN
  // A10 must be known when the WRITE goes out, so the stop decision
  // (including a dropped grant) is taken on beat 0 and held for the burst.
  logic stop_q;
  assign end_burst = stop_q;
`else
  assign end_burst = burst_stop;
`endif

  always_comb begin
    write_addr = '0;
    write_addr[COL_W-1:0] = col;
`ifdef SDRAM_WR_AUTOPRE_EN
    write_addr[10] = burst_stop;
`endif
  end

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      state       <= S_IDLE;
      bank        <= '0;
      act_bank    <= '0;
      row         <= '0;
      col         <= '0;
      remaining   <= '0;
      cnt         <= '0;
      beat        <= '0;
`ifdef SDRAM_WR_AUTOPRE_EN
      stop_q      <= 1'b0;
`endif
      flag_wr_end <= 1'b0;
      sdram_cmd   <= CMD_NOP;
      sdram_addr  <= '0;
      sdram_bank  <= '0;
      sdram_data  <= '0;
    end else begin
      flag_wr_end <= 1'b0;
      sdram_cmd   <= CMD_NOP;
      sdram_addr  <= '0;
      sdram_data  <= wr_data_en ? wr_data : '0;

      case (state)
        S_IDLE: begin
          if (wr_trig && (wr_len != '0)) begin
            bank      <= wr_addr[AW-1 -: BANK_W];
            row       <= wr_addr[COL_W +: ROW_W];
            col       <= wr_addr[COL_W-1:0] & ~COL_W'(BURST - 1);
            remaining <= wr_len;
            state     <= S_ASK;
          end
        end

        S_ASK: begin
          if (wr_en) state <= S_ACT;
        end

        S_ACT: begin
          sdram_cmd  <= CMD_ACT;
          sdram_addr <= row;
          sdram_bank <= bank;
          act_bank   <= bank;
          cnt        <= '0;
          beat       <= '0;
          state      <= (TRCD == 1) ? S_WR : S_RCD;
        end

        S_RCD: begin
          cnt <= cnt + 1'b1;
          if (int'(cnt) + 2 >= TRCD) state <= S_WR;
        end

        S_WR: begin
          if (beat == '0) begin
            sdram_cmd  <= CMD_WR;
            sdram_addr <= write_addr;
            sdram_bank <= bank;
`ifdef SDRAM_WR_AUTOPRE_EN
            stop_q     <= burst_stop;
`endif
          end
          // BURST is a power of two, so the beat counter wraps on its own.
          beat <= beat + 1'b1;
          if (last_beat) begin
            col       <= col_sum[COL_W-1:0];
            remaining <= rem_dec;
            if (row_end) begin
              row <= row_sum[ROW_W-1:0];
              if (row_sum[ROW_W]) bank <= bank + 1'b1;
            end
            if (end_burst) begin
              state <= S_WRREC;
              cnt   <= '0;
            end
          end
        end

        S_WRREC: begin
          cnt <= cnt + 1'b1;
          if (int'(cnt) + 1 >= TWR) begin
            state <= S_PRE;
            cnt   <= '0;
          end
        end

        S_PRE: begin
          if (cnt == '0) begin
`ifndef SDRAM_WR_AUTOPRE_EN
            sdram_cmd <= CMD_PRE;
`endif
            sdram_bank <= act_bank;
          end
          cnt <= cnt + 1'b1;
          if (int'(cnt) + 1 >= TRP) begin
            cnt <= '0;
            if (remaining == '0) begin
              state       <= S_IDLE;
              flag_wr_end <= 1'b1;
            end else if (!wr_en) begin
              state       <= S_ASK;
              flag_wr_end <= 1'b1;
            end else begin
              state <= S_ACT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_wr_burst.sv
// tb/tb_sdram_wr_burst.sv - randomized self-checking bench for sdram_wr_burst
module tb_sdram_wr_burst;
  localparam int DATA_W = 16, ROW_W = 12, COL_W = 9, BANK_W = 2, BURST = 4;
  localparam int LEN_W = 8, TRCD = 2, TWR = 2, TRP = 2;
  localparam int AW = BANK_W + ROW_W + COL_W;
  localparam int MAXC = 16384;
  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRC = 4'b0100, PRE = 4'b0010;

  logic sclk = 1'b0, srst_n = 1'b0, wr_trig = 1'b0, wr_en = 1'b0;
  logic [LEN_W-1:0]  wr_len  = '0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic flag_wr_ask, flag_wr_end, wr_busy, wr_data_en;
  logic [3:0] sdram_cmd;
  logic [ROW_W-1:0] sdram_addr;
  logic [BANK_W-1:0] sdram_bank;
  logic [DATA_W-1:0] sdram_data;

  sdram_wr_burst dut (
    .sclk(sclk), .srst_n(srst_n), .wr_trig(wr_trig), .wr_len(wr_len),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_en(wr_en),
    .flag_wr_ask(flag_wr_ask), .flag_wr_end(flag_wr_end), .wr_busy(wr_busy),
    .wr_data_en(wr_data_en), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank), .sdram_data(sdram_data)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  // Expected outputs per cycle, filled ahead of time by the job model.
  logic [3:0]        exp_cmd  [MAXC];
  logic [ROW_W-1:0]  exp_addr [MAXC];
  logic [BANK_W-1:0] exp_bank [MAXC];
  bit                exp_den  [MAXC];
  bit                exp_ask  [MAXC];
  bit                exp_busy [MAXC];
  bit                exp_end  [MAXC];
  bit                exp_dchk [MAXC];
  logic [DATA_W-1:0] din      [MAXC];

  int n_tests = 0, n_fail = 0;
  int end_cyc = -1;
  int job_t0 = 0;
  bit in_job = 1'b0, asking = 1'b0;
  logic [17:0] ev_q[$];

  task automatic check(input string name, input int c, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, got, exp);
    end
  endtask

  task automatic clear_exp(input int i);
    exp_cmd[i] = NOP; exp_addr[i] = '0; exp_bank[i] = '0;
    exp_den[i] = 0; exp_ask[i] = 0; exp_busy[i] = 0; exp_end[i] = 0; exp_dchk[i] = 0;
  endtask

  always @(negedge sclk) begin
    if (cyc >= 1 && cyc < MAXC) begin
      check("cmd", cyc, 32'(sdram_cmd), 32'(exp_cmd[cyc]));
      check("addr", cyc, 32'(sdram_addr), 32'(exp_addr[cyc]));
      if (exp_cmd[cyc] != NOP) check("bank", cyc, 32'(sdram_bank), 32'(exp_bank[cyc]));
      check("data_en", cyc, 32'(wr_data_en), 32'(exp_den[cyc]));
      check("ask", cyc, 32'(flag_wr_ask), 32'(exp_ask[cyc]));
      check("busy", cyc, 32'(wr_busy), 32'(exp_busy[cyc]));
      check("end", cyc, 32'(flag_wr_end), 32'(exp_end[cyc]));
      if (exp_dchk[cyc]) check("data", cyc, 32'(sdram_data), 32'(din[cyc-1]));
      if (sdram_cmd != NOP) ev_q.push_back({sdram_cmd, sdram_bank, sdram_addr});
      if (flag_wr_end) end_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge sclk); #1;
    if (cyc >= MAXC - 400) begin
      $display("FAIL cycle_budget cyc=%0d exp<%0d", cyc, MAXC - 400);
      $fatal(1, "cycle budget exhausted");
    end
    wr_trig = 1'b0;
    wr_data = DATA_W'($urandom);
    din[cyc] = wr_data;
    exp_busy[cyc] = in_job;
    exp_ask[cyc] = asking;
  endtask

  // Trigger attempts while a job is in flight must be ignored.
  task automatic spurious();
    if ($urandom_range(0, 3) == 0) begin
      wr_trig = 1'b1;
      wr_len  = LEN_W'($urandom);
      wr_addr = AW'($urandom);
    end
  endtask

  task automatic do_abort();
    srst_n = 1'b0;
    for (int i = cyc; i < MAXC && i < cyc + 300; i++) clear_exp(i);
    in_job = 0; asking = 0; wr_en = 1'b0; wr_trig = 1'b0;
    tick();
    srst_n = 1'b1;
  endtask

  // Job model: each grant session is ACT, then J back-to-back bursts,
  // TWR recovery, TRP precharge. J is bounded by the bursts left, the
  // bursts left in the row, and the burst during which the bench drops grant.
  task automatic run_job(input int len, input logic [AW-1:0] addr, input int kd_first,
                         input bit hold, input int abort_off);
    int g, j_n, kd, lim, rowleft, lastbeat, dcyc, p, pend, outcome, w, s, rem, m_col;
    bit dropped, first;
    logic [BANK_W-1:0] m_bank, a_bank;
    logic [ROW_W-1:0] m_row;
    m_bank = addr[AW-1 -: BANK_W];
    m_row  = addr[COL_W +: ROW_W];
    m_col  = int'(addr[COL_W-1:0]) & ~(BURST - 1);
    rem = len;
    wr_trig = 1'b1; wr_len = LEN_W'(len); wr_addr = addr; job_t0 = cyc;
    in_job = 1; asking = 1; first = 1;
    tick();
    forever begin
      w = hold ? 0 : $urandom_range(0, 2);
      for (int i = 0; i < w; i++) begin wr_en = 1'b0; spurious(); tick(); end
      wr_en = 1'b1; g = cyc; asking = 0;
      do begin
        rowleft = ((1 << COL_W) - m_col) / BURST;
        lim = (rem < rowleft) ? rem : rowleft;
        if (hold) kd = lim + 1;
        else if (first && kd_first > 0) kd = kd_first;
        else kd = $urandom_range(1, rem + 1);
        first = 0;
        dropped = (kd <= lim);
        j_n = dropped ? kd : lim;
        exp_cmd[g+2] = ACT; exp_bank[g+2] = m_bank; exp_addr[g+2] = m_row;
        a_bank = m_bank;
        for (int j = 0; j < j_n; j++) begin
          for (int b = 0; b < BURST; b++) begin
            s = g + 1 + TRCD + j * BURST + b;
            exp_den[s] = 1; exp_dchk[s+1] = 1;
          end
          s = g + 2 + TRCD + j * BURST;
          exp_cmd[s] = WRC; exp_bank[s] = m_bank; exp_addr[s] = ROW_W'(m_col);
          m_col += BURST; rem--;
          if (m_col == (1 << COL_W)) begin
            m_col = 0; m_row++;
            if (m_row == '0) m_bank++;
          end
        end
        lastbeat = g + TRCD + j_n * BURST;
        dcyc = lastbeat - $urandom_range(0, BURST - 1);
        p = lastbeat + 1 + TWR;
        pend = p + TRP - 1;
        exp_cmd[p+1] = PRE; exp_bank[p+1] = a_bank; exp_addr[p+1] = '0;
        outcome = (rem == 0) ? 0 : (dropped ? 1 : 2);
        if (outcome != 2) exp_end[pend+1] = 1;
        while (cyc < pend) begin
          tick();
          if (abort_off >= 0 && cyc == g + 1 + TRCD + abort_off) begin do_abort(); return; end
          if (cyc <= lastbeat) wr_en = !(dropped && cyc >= dcyc);
          else wr_en = (outcome == 2);
          spurious();
        end
        g = pend;
      end while (outcome == 2);
      if (outcome == 0) begin in_job = 0; tick(); return; end
      asking = 1;
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin wr_en = $urandom_range(0, 1); tick(); end
  endtask

  task automatic check_events(input string name, input logic [17:0] want[$]);
    check({name, "_count"}, cyc, ev_q.size(), want.size());
    for (int i = 0; i < want.size(); i++)
      check(name, i, (i < ev_q.size()) ? 32'(ev_q[i]) : 32'hxxxx_xxxx, 32'(want[i]));
  endtask

  initial begin
    logic [17:0] want[$];
    logic [AW-1:0] a;
    for (int i = 0; i < MAXC; i++) clear_exp(i);
    srst_n = 1'b0;
    tick(); tick();
    srst_n = 1'b1;
    tick();

    // Single row, grant held: ACT row 5, WRITEs at 0x010/0x014/0x018, PRE.
    ev_q.delete();
    run_job(3, {2'd0, 12'h005, 9'h010}, 0, 1'b1, -1);
    tick();
    want = '{{ACT, 2'd0, 12'h005}, {WRC, 2'd0, 12'h010}, {WRC, 2'd0, 12'h014},
             {WRC, 2'd0, 12'h018}, {PRE, 2'd0, 12'h000}};
    check_events("j1_ev", want);
    check("j1_model_end", job_t0, 32'(exp_end[job_t0+20]), 32'd1);
    check("j1_end_cyc", job_t0, end_cyc - job_t0, 20);
    idle(3);

    // Row and bank crossing: row 0xFFF of bank 1 wraps to row 0 of bank 2.
    ev_q.delete();
    run_job(4, {2'd1, 12'hFFF, 9'h1F8}, 0, 1'b1, -1);
    tick();
    want = '{{ACT, 2'd1, 12'hFFF}, {WRC, 2'd1, 12'h1F8}, {WRC, 2'd1, 12'h1FC},
             {PRE, 2'd1, 12'h000}, {ACT, 2'd2, 12'h000}, {WRC, 2'd2, 12'h000},
             {WRC, 2'd2, 12'h004}, {PRE, 2'd2, 12'h000}};
    check_events("j2_ev", want);
    idle(2);

    // Grant dropped during burst 2 of 5, then regranted.
    run_job(5, {2'd3, 12'h0A0, 9'h040}, 2, 1'b0, -1);
    idle(2);

    // Zero-length trigger is ignored.
    wr_trig = 1'b1; wr_len = '0; wr_addr = AW'($urandom);
    tick();
    idle(4);

    // Reset mid-burst, then a normal job.
    run_job(6, {2'd2, 12'h123, 9'h100}, 0, 1'b1, 5);
    idle(3);
    run_job(2, {2'd0, 12'h010, 9'h1FC}, 0, 1'b1, -1);
    idle(2);

    for (int n = 0; n < 30; n++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1) a[COL_W-1:0] = COL_W'($urandom_range(9'h1E0, 9'h1FF));
      if ($urandom_range(0, 3) == 0) a[COL_W +: ROW_W] = '1;
      run_job($urandom_range(1, 12), a, 0, 1'b0, -1);
      idle($urandom_range(0, 3));
    end

    idle(4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
